// File: rtl/tmr_voter_seq_if.sv
`default_nettype none
// ============================================================================
//  Module   : tmr_voter_seq_if
//  Purpose  : Sample/vote/status bundle between the three datapath replicas,
//             the registered TMR voter and its supervisor.
//  Revision : 1.0  initial release
// ============================================================================
interface tmr_voter_seq_if #(
    parameter int WIDTH = 20,
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] c;
    logic             clr_faults;
    logic             out_valid;
    logic [WIDTH-1:0] v;
    logic [1:0]       error;
    logic             multi_fail;
    logic [2:0]       fault_mask;
    logic [CNT_W-1:0] err_cnt_a;
    logic [CNT_W-1:0] err_cnt_b;
    logic [CNT_W-1:0] err_cnt_c;

    // Producer/supervisor side
    modport master (
        output in_valid, a, b, c, clr_faults,
        input  out_valid, v, error, multi_fail, fault_mask,
        input  err_cnt_a, err_cnt_b, err_cnt_c
    );

    // Voter side
    modport slave (
        input  in_valid, a, b, c, clr_faults,
        output out_valid, v, error, multi_fail, fault_mask,
        output err_cnt_a, err_cnt_b, err_cnt_c
    );
endinterface
`default_nettype wire

// File: rtl/tmr_voter_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tmr_voter_seq
//  Purpose  : Registered TMR voter with per-channel fault tracking. A channel
//             that is the minority FAULT_THRESH times in a row is retired
//             (sticky) and the voter degrades to duplex comparison.
//  Revision : 1.0  initial release
// ============================================================================
module tmr_voter_seq #(
    parameter int WIDTH        = 20,
    parameter int FAULT_THRESH = 4,
    parameter int CNT_W        = 8
) (
    input  wire            clk,
    input  wire            rst_n,
    tmr_voter_seq_if.slave bus
);

    localparam logic [CNT_W-1:0] c_thresh = CNT_W'(FAULT_THRESH);
    localparam logic [CNT_W-1:0] c_one    = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_max    = '1;

    logic             r_out_valid;
    logic [WIDTH-1:0] r_v;
    logic [1:0]       r_error;
    logic             r_multi_fail;
    logic [2:0]       r_fault_mask;
    logic [CNT_W-1:0] r_cnt    [3];
    logic [CNT_W-1:0] r_streak [3];

    logic [2:0]       w_mask_eff;
    logic [CNT_W-1:0] w_cnt_eff [3];
    logic [CNT_W-1:0] w_str_eff [3];
    logic [WIDTH-1:0] w_v_nxt;
    logic [1:0]       w_err_nxt;
    logic             w_mf_nxt;
    logic [2:0]       w_mask_nxt;
    logic [CNT_W-1:0] w_cnt_nxt [3];
    logic [CNT_W-1:0] w_str_nxt [3];

    logic             w_eq_ab;
    logic             w_eq_ac;
    logic             w_eq_bc;
    logic [WIDTH-1:0] w_majority;
    logic             w_min_hit;
    logic [1:0]       w_min_idx;
    logic [WIDTH-1:0] w_min_val;

    assign w_eq_ab    = (bus.a == bus.b);
    assign w_eq_ac    = (bus.a == bus.c);
    assign w_eq_bc    = (bus.b == bus.c);
    assign w_majority = (bus.a & bus.b) | (bus.a & bus.c) | (bus.b & bus.c);

    // Identify a single dissenting channel (index 0=A,1=B,2=C) and the value
    // the other two agree on; no hit when all agree or all disagree.
    always_comb begin
        w_min_hit = 1'b0;
        w_min_idx = 2'd0;
        w_min_val = bus.b;
        if (w_eq_ab && w_eq_bc) begin
            w_min_hit = 1'b0;
        end else if (w_eq_bc) begin
            w_min_hit = 1'b1;
            w_min_idx = 2'd0;
            w_min_val = bus.b;
        end else if (w_eq_ac) begin
            w_min_hit = 1'b1;
            w_min_idx = 2'd1;
            w_min_val = bus.a;
        end else if (w_eq_ab) begin
            w_min_hit = 1'b1;
            w_min_idx = 2'd2;
            w_min_val = bus.a;
        end
    end

    // Vote and status next-state. A clear pulse is applied first so that a
    // sample arriving in the same cycle is voted against the cleared state.
    always_comb begin
        w_mask_eff = bus.clr_faults ? 3'b000 : r_fault_mask;
        for (int i = 0; i < 3; i++) begin
            w_cnt_eff[i] = bus.clr_faults ? '0 : r_cnt[i];
            w_str_eff[i] = bus.clr_faults ? '0 : r_streak[i];
        end

        w_v_nxt    = r_v;
        w_err_nxt  = r_error;
        w_mf_nxt   = r_multi_fail;
        w_mask_nxt = w_mask_eff;
        for (int i = 0; i < 3; i++) begin
            w_cnt_nxt[i] = w_cnt_eff[i];
            w_str_nxt[i] = w_str_eff[i];
        end

        if (bus.in_valid) begin
            w_err_nxt = 2'd0;
            w_mf_nxt  = 1'b0;
            case (w_mask_eff)
                3'b000: begin
                    if (w_eq_ab && w_eq_bc) begin
                        w_v_nxt = bus.a;
                        for (int i = 0; i < 3; i++) begin
                            w_str_nxt[i] = '0;
                        end
                    end else if (w_min_hit) begin
                        w_v_nxt   = w_min_val;
                        w_err_nxt = w_min_idx + 2'd1;
                        for (int i = 0; i < 3; i++) begin
                            if (2'(i) == w_min_idx) begin
                                w_str_nxt[i] = (w_str_eff[i] == c_max) ? c_max : w_str_eff[i] + c_one;
                                w_cnt_nxt[i] = (w_cnt_eff[i] == c_max) ? c_max : w_cnt_eff[i] + c_one;
                                if (w_str_nxt[i] >= c_thresh) begin
                                    w_mask_nxt[i] = 1'b1;
                                end
                            end else begin
                                w_str_nxt[i] = '0;
                            end
                        end
                    end else begin
                        // No two channels agree: best-effort bitwise majority
                        w_v_nxt  = w_majority;
                        w_mf_nxt = 1'b1;
                    end
                end
                // Duplex: a disagreement cannot be attributed, so v holds
                3'b001: begin
                    if (w_eq_bc) w_v_nxt = bus.b;
                    else         w_mf_nxt = 1'b1;
                end
                3'b010: begin
                    if (w_eq_ac) w_v_nxt = bus.a;
                    else         w_mf_nxt = 1'b1;
                end
                3'b100: begin
                    if (w_eq_ab) w_v_nxt = bus.a;
                    else         w_mf_nxt = 1'b1;
                end
                // Two or more retired. Only one channel can retire per TMR
                // vote and duplex never retires, so this is unreachable in
                // practice; kept as a defined fallback.
                default: begin
                    w_mf_nxt = 1'b1;
                    if (!w_mask_eff[0])      w_v_nxt = bus.a;
                    else if (!w_mask_eff[1]) w_v_nxt = bus.b;
                    else if (!w_mask_eff[2]) w_v_nxt = bus.c;
                    else                     w_v_nxt = bus.a;
                end
            endcase
        end
    end

    // Output and status registers; one cycle of latency, async reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid  <= 1'b0;
            r_v          <= '0;
            r_error      <= 2'd0;
            r_multi_fail <= 1'b0;
            r_fault_mask <= 3'b000;
            for (int i = 0; i < 3; i++) begin
                r_cnt[i]    <= '0;
                r_streak[i] <= '0;
            end
        end else begin
            r_out_valid  <= bus.in_valid;
            r_v          <= w_v_nxt;
            r_error      <= w_err_nxt;
            r_multi_fail <= w_mf_nxt;
            r_fault_mask <= w_mask_nxt;
            for (int i = 0; i < 3; i++) begin
                r_cnt[i]    <= w_cnt_nxt[i];
                r_streak[i] <= w_str_nxt[i];
            end
        end
    end

    assign bus.out_valid  = r_out_valid;
    assign bus.v          = r_v;
    assign bus.error      = r_error;
    assign bus.multi_fail = r_multi_fail;
    assign bus.fault_mask = r_fault_mask;
    assign bus.err_cnt_a  = r_cnt[0];
    assign bus.err_cnt_b  = r_cnt[1];
    assign bus.err_cnt_c  = r_cnt[2];

endmodule
`default_nettype wire

// File: tb/tb_tmr_voter_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tmr_voter_seq
//  Purpose  : Self-checking bench for tmr_voter_seq: directed vector table,
//             saturation/clear sequence on a narrow-counter instance, and
//             randomized traffic against a behavioural reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_tmr_voter_seq;

    localparam int W      = 20;
    localparam int THRESH = 4;
    localparam int CMAX   = 255;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tmr_voter_seq_if #(.WIDTH(W), .CNT_W(8)) m_if ();
    tmr_voter_seq_if #(.WIDTH(W), .CNT_W(2)) s_if ();

    tmr_voter_seq #(.WIDTH(W), .FAULT_THRESH(THRESH), .CNT_W(8)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (m_if.slave)
    );

    tmr_voter_seq #(.WIDTH(W), .FAULT_THRESH(3), .CNT_W(2)) u_dut_s (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (s_if.slave)
    );

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic          vld;
        logic          clr;
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic [W-1:0]  c;
        logic          ov;
        logic [W-1:0]  v;
        logic [1:0]    err;
        logic          mf;
        logic [2:0]    mask;
        logic [7:0]    ca;
        logic [7:0]    cb;
        logic [7:0]    cc;
    } vec_t;

    vec_t tbl [23];

    // reference model state
    logic          m_ov;
    logic [W-1:0]  m_v;
    logic [1:0]    m_err;
    logic          m_mf;
    logic [2:0]    m_mask;
    int            m_cnt [3];
    int            m_str [3];

    function automatic logic [63:0] pk(input logic ov, input logic [W-1:0] v, input logic [1:0] err,
                                       input logic mf, input logic [2:0] mask,
                                       input logic [7:0] ca, input logic [7:0] cb, input logic [7:0] cc);
        return {13'd0, ov, v, err, mf, mask, ca, cb, cc};
    endfunction

    function automatic logic [63:0] pk_m();
        return pk(m_if.out_valid, m_if.v, m_if.error, m_if.multi_fail, m_if.fault_mask,
                  m_if.err_cnt_a, m_if.err_cnt_b, m_if.err_cnt_c);
    endfunction

    function automatic logic [63:0] pk_s();
        return pk(s_if.out_valid, s_if.v, s_if.error, s_if.multi_fail, s_if.fault_mask,
                  {6'd0, s_if.err_cnt_a}, {6'd0, s_if.err_cnt_b}, {6'd0, s_if.err_cnt_c});
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h {ov,v,err,mf,mask,ca,cb,cc}", nm, act, exp);
        end
    endtask

    task automatic drive_m(input logic vld, input logic clr, input logic [W-1:0] ia,
                           input logic [W-1:0] ib, input logic [W-1:0] ic);
        @(negedge clk);
        m_if.in_valid   = vld;
        m_if.clr_faults = clr;
        m_if.a          = ia;
        m_if.b          = ib;
        m_if.c          = ic;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_s(input logic vld, input logic clr, input logic [W-1:0] ia,
                           input logic [W-1:0] ib, input logic [W-1:0] ic);
        @(negedge clk);
        s_if.in_valid   = vld;
        s_if.clr_faults = clr;
        s_if.a          = ia;
        s_if.b          = ib;
        s_if.c          = ic;
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_ov = 1'b0; m_v = '0; m_err = 2'd0; m_mf = 1'b0; m_mask = 3'b000;
        for (int i = 0; i < 3; i++) begin
            m_cnt[i] = 0;
            m_str[i] = 0;
        end
    endtask

    // Behavioural voter: classify by how many peers each live channel agrees with
    task automatic model_step(input logic vld, input logic clr, input logic [W-1:0] ia,
                              input logic [W-1:0] ib, input logic [W-1:0] ic);
        logic [W-1:0] ch [3];
        int surv [$];
        int agree [3];
        int tot;
        ch[0] = ia; ch[1] = ib; ch[2] = ic;
        m_ov = vld;
        if (clr) begin
            m_mask = 3'b000;
            for (int i = 0; i < 3; i++) begin
                m_cnt[i] = 0;
                m_str[i] = 0;
            end
        end
        if (!vld) return;
        m_err = 2'd0;
        m_mf  = 1'b0;
        for (int i = 0; i < 3; i++) if (!m_mask[i]) surv.push_back(i);
        if (surv.size() == 3) begin
            tot = 0;
            for (int i = 0; i < 3; i++) begin
                agree[i] = int'(ch[i] == ch[(i+1)%3]) + int'(ch[i] == ch[(i+2)%3]);
                tot += agree[i];
            end
            if (tot == 6) begin
                m_v = ia;
                for (int i = 0; i < 3; i++) m_str[i] = 0;
            end else if (tot == 2) begin
                for (int i = 0; i < 3; i++) begin
                    if (agree[i] == 0) begin
                        m_v   = ch[(i+1)%3];
                        m_err = 2'(i + 1);
                        m_str[i]++;
                        if (m_cnt[i] < CMAX) m_cnt[i]++;
                        if (m_str[i] >= THRESH) m_mask[i] = 1'b1;
                    end else begin
                        m_str[i] = 0;
                    end
                end
            end else begin
                for (int k = 0; k < W; k++)
                    m_v[k] = (int'(ia[k]) + int'(ib[k]) + int'(ic[k])) >= 2;
                m_mf = 1'b1;
            end
        end else if (surv.size() == 2) begin
            if (ch[surv[0]] == ch[surv[1]]) m_v = ch[surv[0]];
            else                            m_mf = 1'b1;
        end else begin
            m_v  = (surv.size() == 1) ? ch[surv[0]] : ia;
            m_mf = 1'b1;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        //                vld   clr   a         b         c          ov    v         err   mf    mask     ca     cb     cc
        tbl[0]  = '{1'b1, 1'b0, 20'h12345, 20'h12345, 20'h12345, 1'b1, 20'h12345, 2'd0, 1'b0, 3'b000, 8'd0, 8'd0, 8'd0};
        tbl[1]  = '{1'b1, 1'b0, 20'h00001, 20'h0F0F0, 20'h0F0F0, 1'b1, 20'h0F0F0, 2'd1, 1'b0, 3'b000, 8'd1, 8'd0, 8'd0};
        tbl[2]  = '{1'b1, 1'b0, 20'h00777, 20'h00777, 20'h00777, 1'b1, 20'h00777, 2'd0, 1'b0, 3'b000, 8'd1, 8'd0, 8'd0};
        tbl[3]  = '{1'b0, 1'b0, 20'h00000, 20'h00000, 20'h00000, 1'b0, 20'h00777, 2'd0, 1'b0, 3'b000, 8'd1, 8'd0, 8'd0};
        tbl[4]  = '{1'b1, 1'b0, 20'h00011, 20'h00022, 20'h00022, 1'b1, 20'h00022, 2'd1, 1'b0, 3'b000, 8'd2, 8'd0, 8'd0};
        tbl[5]  = '{1'b1, 1'b0, 20'h00011, 20'h00022, 20'h00022, 1'b1, 20'h00022, 2'd1, 1'b0, 3'b000, 8'd3, 8'd0, 8'd0};
        tbl[6]  = '{1'b1, 1'b0, 20'h00011, 20'h00022, 20'h00022, 1'b1, 20'h00022, 2'd1, 1'b0, 3'b000, 8'd4, 8'd0, 8'd0};
        tbl[7]  = '{1'b1, 1'b0, 20'h00033, 20'h00033, 20'h00033, 1'b1, 20'h00033, 2'd0, 1'b0, 3'b000, 8'd4, 8'd0, 8'd0};
        tbl[8]  = '{1'b1, 1'b0, 20'h00044, 20'h00055, 20'h00055, 1'b1, 20'h00055, 2'd1, 1'b0, 3'b000, 8'd5, 8'd0, 8'd0};
        tbl[9]  = '{1'b1, 1'b0, 20'h00005, 20'h00005, 20'h00009, 1'b1, 20'h00005, 2'd3, 1'b0, 3'b000, 8'd5, 8'd0, 8'd1};
        tbl[10] = '{1'b1, 1'b0, 20'h00005, 20'h00005, 20'h00009, 1'b1, 20'h00005, 2'd3, 1'b0, 3'b000, 8'd5, 8'd0, 8'd2};
        tbl[11] = '{1'b1, 1'b0, 20'h00005, 20'h00005, 20'h00009, 1'b1, 20'h00005, 2'd3, 1'b0, 3'b000, 8'd5, 8'd0, 8'd3};
        tbl[12] = '{1'b1, 1'b0, 20'h00005, 20'h00005, 20'h00009, 1'b1, 20'h00005, 2'd3, 1'b0, 3'b100, 8'd5, 8'd0, 8'd4};
        tbl[13] = '{1'b1, 1'b0, 20'h00005, 20'h00005, 20'h00009, 1'b1, 20'h00005, 2'd0, 1'b0, 3'b100, 8'd5, 8'd0, 8'd4};
        tbl[14] = '{1'b1, 1'b0, 20'hAAAAA, 20'h55555, 20'h00000, 1'b1, 20'h00005, 2'd0, 1'b1, 3'b100, 8'd5, 8'd0, 8'd4};
        tbl[15] = '{1'b0, 1'b0, 20'h00000, 20'h00000, 20'h00000, 1'b0, 20'h00005, 2'd0, 1'b1, 3'b100, 8'd5, 8'd0, 8'd4};
        tbl[16] = '{1'b1, 1'b0, 20'h00123, 20'h00123, 20'h00ABC, 1'b1, 20'h00123, 2'd0, 1'b0, 3'b100, 8'd5, 8'd0, 8'd4};
        tbl[17] = '{1'b1, 1'b0, 20'h00001, 20'h00002, 20'h00002, 1'b1, 20'h00123, 2'd0, 1'b1, 3'b100, 8'd5, 8'd0, 8'd4};
        tbl[18] = '{1'b1, 1'b1, 20'h0000F, 20'h000F0, 20'h000FF, 1'b1, 20'h000FF, 2'd0, 1'b1, 3'b000, 8'd0, 8'd0, 8'd0};
        tbl[19] = '{1'b1, 1'b0, 20'h0000F, 20'h000F0, 20'h000FF, 1'b1, 20'h000FF, 2'd0, 1'b1, 3'b000, 8'd0, 8'd0, 8'd0};
        tbl[20] = '{1'b1, 1'b0, 20'h00001, 20'h00001, 20'h00002, 1'b1, 20'h00001, 2'd3, 1'b0, 3'b000, 8'd0, 8'd0, 8'd1};
        tbl[21] = '{1'b0, 1'b1, 20'h00000, 20'h00000, 20'h00000, 1'b0, 20'h00001, 2'd3, 1'b0, 3'b000, 8'd0, 8'd0, 8'd0};
        tbl[22] = '{1'b1, 1'b0, 20'h00000, 20'h00000, 20'h00000, 1'b1, 20'h00000, 2'd0, 1'b0, 3'b000, 8'd0, 8'd0, 8'd0};

        m_if.in_valid = 1'b0; m_if.clr_faults = 1'b0; m_if.a = '0; m_if.b = '0; m_if.c = '0;
        s_if.in_valid = 1'b0; s_if.clr_faults = 1'b0; s_if.a = '0; s_if.b = '0; s_if.c = '0;
        model_reset();

        // ---- reset state ----
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_main", pk_m(), 64'd0);
        check("reset_small", pk_s(), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // ---- directed vector table ----
        for (int i = 0; i < 23; i++) begin
            drive_m(tbl[i].vld, tbl[i].clr, tbl[i].a, tbl[i].b, tbl[i].c);
            check($sformatf("tbl[%0d]", i), pk_m(),
                  pk(tbl[i].ov, tbl[i].v, tbl[i].err, tbl[i].mf, tbl[i].mask,
                     tbl[i].ca, tbl[i].cb, tbl[i].cc));
        end

        // ---- reset mid-stream: in-flight sample is discarded ----
        drive_m(1'b1, 1'b0, 20'h00003, 20'h00003, 20'h00003);
        check("midrst_pre", pk_m(), pk(1'b1, 20'h00003, 2'd0, 1'b0, 3'b000, 8'd0, 8'd0, 8'd0));
        m_if.a = 20'h00004; m_if.b = 20'h00004; m_if.c = 20'h00004;
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_async", pk_m(), 64'd0);
        m_if.in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_after", pk_m(), 64'd0);

        // ---- narrow counters: saturation, clear with same-cycle sample, retirement ----
        begin
            logic [1:0] e_cb   [13] = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd1, 2'd2, 2'd3, 2'd3};
            logic       bmin   [13] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
            logic       clr    [13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
            logic [2:0] e_mask [13] = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000,
                                       3'b000, 3'b000, 3'b000, 3'b000, 3'b010, 3'b010};
            logic [1:0] e_err  [13] = '{2'd2, 2'd0, 2'd2, 2'd0, 2'd2, 2'd0, 2'd2, 2'd0, 2'd2, 2'd2, 2'd2, 2'd2, 2'd0};
            for (int i = 0; i < 13; i++) begin
                drive_s(1'b1, clr[i], 20'h00001, bmin[i] ? 20'h00002 : 20'h00001, 20'h00001);
                check($sformatf("small[%0d]", i), pk_s(),
                      pk(1'b1, 20'h00001, e_err[i], 1'b0, e_mask[i], 8'd0, {6'd0, e_cb[i]}, 8'd0));
            end
            drive_s(1'b0, 1'b0, '0, '0, '0);
        end

        // ---- randomized traffic against the reference model ----
        @(negedge clk);
        rst_n = 1'b0;
        m_if.in_valid = 1'b0; m_if.clr_faults = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        begin
            int bad = 3;
            for (int n = 0; n < 800; n++) begin
                logic [W-1:0] base;
                logic [W-1:0] ch [3];
                logic vld;
                logic clr;
                if (n % 40 == 0) bad = int'($urandom_range(0, 3));
                base = W'($urandom);
                for (int k = 0; k < 3; k++) begin
                    logic dev;
                    dev   = (k == bad) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 9) == 0);
                    ch[k] = dev ? (base ^ (W'($urandom) | W'(1))) : base;
                end
                vld = ($urandom_range(0, 7) != 0);
                clr = ($urandom_range(0, 39) == 0);
                drive_m(vld, clr, ch[0], ch[1], ch[2]);
                model_step(vld, clr, ch[0], ch[1], ch[2]);
                check($sformatf("rand[%0d]", n), pk_m(),
                      pk(m_ov, m_v, m_err, m_mf, m_mask, 8'(m_cnt[0]), 8'(m_cnt[1]), 8'(m_cnt[2])));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
